dma_controller: RTL and testbench
=================================

DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 SHALL have parameter base_address, default 32'h40E0, byte address of the four-register window (+0 SRC, +4 DST, +8 COUNT, +C CTRL).
REQ-002 SHALL have ports: clk  input  1  system clock, rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have data_bus_read  output  32  register read data to the slave bus.
REQ-005 SHALL have data_bus_write  input  32; data_bus_select  input  1; data_bus_addr  input  32; data_bus_mode  input  2, the slave side.
REQ-006 SHALL have dma_bus_req  output  1  bus ownership request; dma_bus_grant  input  1  ownership granted by bus_arbiter.
REQ-007 SHALL have dma_address  output  32; dma_write_data  output  32; dma_mode  output  2; dma_reqw  output  2 (always word); dma_reqs  output  1 (always 0); dma_read_data  input  32, the master side.
REQ-008 SHALL have dma_irq  output  1  transfer-complete interrupt, routed to the ICU irq_sources.
REQ-009 Bus mode encoding SHALL be 2'b00 idle, 2'b01 read, 2'b10 write; read data SHALL be valid the cycle after the read address is presented.

Function
REQ-010 Register access SHALL occur only when data_bus_select=1; data_bus_read SHALL be 0 when unselected or when mode is not read.
REQ-011 SRC and DST SHALL be 32-bit, bits [1:0] forced to 0; COUNT SHALL be 16-bit word count; all SHALL read back their current (live) values.
REQ-012 CTRL bits: [0] START (write 1, reads 0), [1] BUSY (RO), [2] DONE (write 1 clears), [3] IRQ_EN (RW), [4] ABORT (write 1, reads 0).
REQ-013 Writes to SRC, DST, COUNT and IRQ_EN while BUSY=1 SHALL be ignored.
REQ-014 FSM states SHALL be IDLE, REQ, RD, RD_WAIT, WR, FIN.
REQ-015 IDLE->REQ on START with COUNT!=0; START with COUNT=0 SHALL go directly to FIN with no bus transaction.
REQ-016 dma_bus_req SHALL be 1 in REQ, RD, RD_WAIT, WR; REQ->RD when dma_bus_grant=1.
REQ-017 RD SHALL drive dma_address=SRC, dma_mode=01 for one cycle; RD_WAIT SHALL latch dma_read_data into a 32-bit buffer.
REQ-018 WR SHALL drive dma_address=DST, dma_write_data=buffer, dma_mode=10 for one cycle, then SRC+=4, DST+=4, COUNT-=1.
REQ-019 After WR: COUNT (post-decrement) !=0 -> RD; ==0 -> FIN; each word SHALL take exactly 3 cycles when granted.
REQ-020 If dma_bus_grant=0 in RD, RD_WAIT or WR, the FSM SHALL hold state, drive dma_mode=00 and repeat the access once granted.
REQ-021 SRC/DST increments SHALL wrap modulo 2^32.
REQ-022 FIN SHALL set DONE=1, clear BUSY, go to IDLE in one cycle; BUSY=1 in all states except IDLE.
REQ-023 ABORT while busy SHALL take effect after the current WR (or immediately in REQ): return to IDLE, DONE unchanged, SRC/DST/COUNT reflecting completed words.
REQ-024 START while BUSY=1 SHALL be ignored; simultaneous DONE clear and FIN set SHALL leave DONE=1.
REQ-025 dma_mode SHALL be 00 in IDLE, REQ, FIN.

Reset
REQ-026 On reset=0: state IDLE, all registers 0, buffer 0, dma_bus_req=0, dma_mode=00, dma_address=0, dma_write_data=0, dma_irq=0.
REQ-027 Reset mid-transfer SHALL abandon the transfer immediately with no further bus cycles.

Configuration
REQ-028 Macro FEATURE_DMA_IRQ_EN SHALL gate the interrupt.
REQ-029 Defined: dma_irq = DONE & IRQ_EN, level, cleared by writing DONE=1.
REQ-030 Undefined: dma_irq tied 0, IRQ_EN reads 0 and ignores writes; all else unchanged.

Verification
REQ-031 SRC=0x1000, DST=0x2000, COUNT=4, START, grant held -> 4 reads then 4 writes interleaved, DST words equal source, BUSY for 1+12+1 cycles, DONE=1.
REQ-032 COUNT=0, START -> no dma_mode!=00 ever, DONE=1 after 1 cycle, BUSY pulse of 1 cycle.
REQ-033 COUNT=3, grant dropped 2 cycles during second RD -> dma_mode=00 while ungranted, read of SRC+4 reissued, final data correct.
REQ-034 SRC=0xFFFFFFFC, COUNT=2 -> second read at 0x00000000.
REQ-035 COUNT=8, ABORT after 2nd word -> IDLE after a WR, COUNT=6 (or 5 if the WR in progress completed), DONE=0; write to SRC during busy ignored.
REQ-036 FEATURE_DMA_IRQ_EN defined, IRQ_EN=1 -> dma_irq rises with DONE, falls after DONE write-1-clear; undefined -> dma_irq stays 0.

Source files
------------

// File: rtl/dma_controller.sv
// Single-channel word DMA: slave register window (+0 SRC, +4 DST, +8 COUNT, +C CTRL) plus a bus master.
// Latency: 3 cycles per word when granted (RD, RD_WAIT, WR); register reads are combinational.
// Backpressure: dma_bus_grant low stalls RD/RD_WAIT/WR with dma_mode idle; FEATURE_DMA_IRQ_EN enables dma_irq.
module dma_controller #(
  parameter logic [31:0] base_address = 32'h40E0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] data_bus_read,
  input  logic [31:0] data_bus_write,
  input  logic        data_bus_select,
  input  logic [31:0] data_bus_addr,
  input  logic [1:0]  data_bus_mode,
  output logic        dma_bus_req,
  input  logic        dma_bus_grant,
  output logic [31:0] dma_address,
  output logic [31:0] dma_write_data,
  output logic [1:0]  dma_mode,
  output logic [1:0]  dma_reqw,
  output logic        dma_reqs,
  input  logic [31:0] dma_read_data,
  output logic        dma_irq
);

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;
  localparam logic [1:0] SIZE_WORD  = 2'b10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_RD      = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_WR      = 3'd4;
  localparam logic [2:0] ST_FIN     = 3'd5;

  logic [2:0]  state;
  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] count;
  logic [31:0] buffer;
  logic        done;
  logic        abort_pend;
  logic        irq_en_rd;

  logic busy;
  logic bus_wr;
  logic bus_rd;
  logic hit_src;
  logic hit_dst;
  logic hit_count;
  logic hit_ctrl;
  logic ctrl_wr;
  logic start_req;
  logic abort_req;
  logic abort_now;
  logic wr_fire;

  assign busy      = (state != ST_IDLE);
  assign bus_wr    = data_bus_select && (data_bus_mode == MODE_WRITE);
  assign bus_rd    = data_bus_select && (data_bus_mode == MODE_READ);
  assign hit_src   = (data_bus_addr == base_address);
  assign hit_dst   = (data_bus_addr == base_address + 32'h4);
  assign hit_count = (data_bus_addr == base_address + 32'h8);
  assign hit_ctrl  = (data_bus_addr == base_address + 32'hC);
  assign ctrl_wr   = bus_wr && hit_ctrl;
  assign start_req = ctrl_wr && data_bus_write[0] && !busy;
  // An abort that lands in FIN is moot: the transfer is already complete.
  assign abort_req = ctrl_wr && data_bus_write[4] && busy && (state != ST_FIN);
  assign abort_now = abort_pend || abort_req;
  assign wr_fire   = (state == ST_WR) && dma_bus_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            state <= (count == 16'd0) ? ST_FIN : ST_REQ;
          end
        end
        ST_REQ: begin
          if (abort_now) begin
            state <= ST_IDLE;
          end else if (dma_bus_grant) begin
            state <= ST_RD;
          end
        end
        ST_RD: begin
          if (dma_bus_grant) begin
            state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (dma_bus_grant) begin
            state <= ST_WR;
          end
        end
        ST_WR: begin
          if (dma_bus_grant) begin
            if (abort_now) begin
              state <= ST_IDLE;
            end else if (count == 16'd1) begin
              state <= ST_FIN;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Software writes only land while idle, so they never collide with the WR-stage updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src <= 32'd0;
    end else if (bus_wr && hit_src && !busy) begin
      src <= {data_bus_write[31:2], 2'b00};
    end else if (wr_fire) begin
      src <= src + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dst <= 32'd0;
    end else if (bus_wr && hit_dst && !busy) begin
      dst <= {data_bus_write[31:2], 2'b00};
    end else if (wr_fire) begin
      dst <= dst + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 16'd0;
    end else if (bus_wr && hit_count && !busy) begin
      count <= data_bus_write[15:0];
    end else if (wr_fire) begin
      count <= count - 16'd1;
    end
  end

  // Read data is held by the source until the next read, so a stalled RD_WAIT still sees it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buffer <= 32'd0;
    end else if ((state == ST_RD_WAIT) && dma_bus_grant) begin
      buffer <= dma_read_data;
    end
  end

  // FIN wins over a same-cycle write-1-clear so a completion is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
    end else if (state == ST_FIN) begin
      done <= 1'b1;
    end else if (ctrl_wr && data_bus_write[2]) begin
      done <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      abort_pend <= 1'b0;
    end else if (!busy || (state == ST_FIN)) begin
      abort_pend <= 1'b0;
    end else if (abort_req) begin
      abort_pend <= 1'b1;
    end
  end

`ifdef FEATURE_DMA_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en <= 1'b0;
    end else if (ctrl_wr && !busy) begin
      irq_en <= data_bus_write[3];
    end
  end

  assign irq_en_rd = irq_en;
  assign dma_irq   = done && irq_en;
`else
  assign irq_en_rd = 1'b0;
  assign dma_irq   = 1'b0;
`endif

  always_comb begin
    data_bus_read = 32'd0;
    if (bus_rd) begin
      if (hit_src) begin
        data_bus_read = src;
      end else if (hit_dst) begin
        data_bus_read = dst;
      end else if (hit_count) begin
        data_bus_read = {16'd0, count};
      end else if (hit_ctrl) begin
        data_bus_read = {27'd0, 1'b0, irq_en_rd, done, busy, 1'b0};
      end
    end
  end

  always_comb begin
    dma_bus_req    = (state == ST_REQ) || (state == ST_RD) ||
                     (state == ST_RD_WAIT) || (state == ST_WR);
    dma_address    = 32'd0;
    dma_write_data = 32'd0;
    dma_mode       = MODE_IDLE;
    if (state == ST_RD) begin
      dma_address = src;
      if (dma_bus_grant) begin
        dma_mode = MODE_READ;
      end
    end else if (state == ST_WR) begin
      dma_address    = dst;
      dma_write_data = buffer;
      if (dma_bus_grant) begin
        dma_mode = MODE_WRITE;
      end
    end
  end

  assign dma_reqw = SIZE_WORD;
  assign dma_reqs = 1'b0;

endmodule

// File: tb/tb_dma_controller.sv
// Bench for dma_controller: transaction-level model of expected bus accesses and register state,
// directed scenarios plus randomized transfers with random grant.
module tb_dma_controller;

  localparam logic [31:0] BASE = 32'h40E0;

  logic        clk;
  logic        reset;
  logic [31:0] data_bus_read;
  logic [31:0] data_bus_write;
  logic        data_bus_select;
  logic [31:0] data_bus_addr;
  logic [1:0]  data_bus_mode;
  logic        dma_bus_req;
  logic        dma_bus_grant;
  logic [31:0] dma_address;
  logic [31:0] dma_write_data;
  logic [1:0]  dma_mode;
  logic [1:0]  dma_reqw;
  logic        dma_reqs;
  logic [31:0] dma_read_data;
  logic        dma_irq;

  dma_controller #(.base_address(BASE)) dut (
    .clk(clk), .reset(reset),
    .data_bus_read(data_bus_read), .data_bus_write(data_bus_write),
    .data_bus_select(data_bus_select), .data_bus_addr(data_bus_addr),
    .data_bus_mode(data_bus_mode),
    .dma_bus_req(dma_bus_req), .dma_bus_grant(dma_bus_grant),
    .dma_address(dma_address), .dma_write_data(dma_write_data),
    .dma_mode(dma_mode), .dma_reqw(dma_reqw), .dma_reqs(dma_reqs),
    .dma_read_data(dma_read_data), .dma_irq(dma_irq)
  );

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  acc_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   wr_seen = 0;
  int   cyc = 0;
  int   drop_at = -100;
  bit   grant_rand = 0;

  logic [31:0] src_m, dst_m;
  logic [15:0] cnt_m;
  logic        done_m, irqen_m, ie_w;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h1234};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory: read data appears the cycle after the read address and holds until the next read.
  initial begin
    logic [1:0]  m;
    logic [31:0] a;
    dma_read_data = 32'd0;
    forever begin
      @(posedge clk);
      m = dma_mode;
      a = dma_address;
      #1;
      if (m == 2'b01) dma_read_data = memf(a);
    end
  end

  initial begin
    dma_bus_grant = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= drop_at && cyc < drop_at + 2) dma_bus_grant = 1'b0;
      else if (grant_rand) dma_bus_grant = ($urandom_range(0, 3) != 0);
      else dma_bus_grant = 1'b1;
    end
  end

  // Per-cycle compare of every bus access against the expected access stream.
  initial begin
    acc_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("reset_mode", 32'(dma_mode), 32'd0);
        check("reset_req", 32'(dma_bus_req), 32'd0);
        check("reset_addr", dma_address, 32'd0);
        check("reset_wdata", dma_write_data, 32'd0);
        check("reset_irq", 32'(dma_irq), 32'd0);
      end else begin
        if (dma_mode != 2'b00) begin
          check("req_during_access", 32'(dma_bus_req), 32'd1);
          check("access_only_granted", 32'(dma_bus_grant), 32'd1);
          if (expq.size() == 0) begin
            check("unexpected_access_mode", 32'(dma_mode), 32'd0);
          end else begin
            e = expq.pop_front();
            check("acc_mode", 32'(dma_mode), 32'(e.mode));
            check("acc_addr", dma_address, e.addr);
            if (e.mode == 2'b10) check("acc_wdata", dma_write_data, e.data);
          end
          if (dma_mode == 2'b10) wr_seen++;
        end
        if (!(data_bus_select && data_bus_mode == 2'b01))
          check("rdata_unselected", data_bus_read, 32'd0);
`ifndef FEATURE_DMA_IRQ_EN
        check("irq_tied_low", 32'(dma_irq), 32'd0);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [3:0] off, input logic [31:0] d);
    data_bus_select = 1'b1;
    data_bus_mode   = 2'b10;
    data_bus_addr   = BASE + {28'd0, off};
    data_bus_write  = d;
    tick();
    data_bus_select = 1'b0;
    data_bus_mode   = 2'b00;
  endtask

  task automatic cpu_read(input logic [3:0] off, output logic [31:0] d);
    data_bus_select = 1'b1;
    data_bus_mode   = 2'b01;
    data_bus_addr   = BASE + {28'd0, off};
    @(negedge clk);
    d = data_bus_read;
    tick();
    data_bus_select = 1'b0;
    data_bus_mode   = 2'b00;
  endtask

  function automatic logic irq_exp();
`ifdef FEATURE_DMA_IRQ_EN
    return done_m & irqen_m;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ctrl_exp();
    return 32'({irqen_m, done_m, 2'b00});
  endfunction

  task automatic verify_regs(input string tag);
    logic [31:0] v;
    cpu_read(4'h0, v); check({tag, "_src"}, v, src_m);
    cpu_read(4'h4, v); check({tag, "_dst"}, v, dst_m);
    cpu_read(4'h8, v); check({tag, "_count"}, v, {16'd0, cnt_m});
    cpu_read(4'hC, v); check({tag, "_ctrl"}, v, ctrl_exp());
    check({tag, "_irq"}, 32'(dma_irq), 32'(irq_exp()));
  endtask

  task automatic program_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n, input logic ie);
    ie_w = ie;
    cpu_write(4'hC, 32'({ie, 1'b1, 2'b00}));
    cpu_write(4'h0, s | 32'($urandom_range(0, 3)));
    cpu_write(4'h4, d | 32'($urandom_range(0, 3)));
    cpu_write(4'h8, {16'($urandom), n});
    src_m  = {s[31:2], 2'b00};
    dst_m  = {d[31:2], 2'b00};
    cnt_m  = n;
    done_m = 1'b0;
`ifdef FEATURE_DMA_IRQ_EN
    irqen_m = ie;
`else
    irqen_m = 1'b0;
`endif
    for (int i = 0; i < int'(n); i++) begin
      expq.push_back({2'b01, src_m + 32'(4 * i), 32'd0});
      expq.push_back({2'b10, dst_m + 32'(4 * i), memf(src_m + 32'(4 * i))});
    end
  endtask

  task automatic poll_idle(output int busy_cycles, output logic [31:0] last);
    busy_cycles = 0;
    last = 32'd0;
    for (int k = 0; k < 600; k++) begin
      cpu_read(4'hC, last);
      if (!last[1]) break;
      busy_cycles++;
    end
    if (last[1]) check("poll_timeout_busy", last, 32'd0);
  endtask

  task automatic start_and_wait(output int busy_cycles, output logic [31:0] last);
    cpu_write(4'hC, 32'({ie_w, 1'b0, 2'b01}));
    poll_idle(busy_cycles, last);
  endtask

  task automatic finish_model(input string tag);
    check({tag, "_leftover"}, 32'(expq.size()), 32'd0);
    expq.delete();
    src_m  = src_m + 32'(4 * int'(cnt_m));
    dst_m  = dst_m + 32'(4 * int'(cnt_m));
    cnt_m  = 16'd0;
    done_m = 1'b1;
  endtask

  task automatic drop_grant_second_rd();
    int base;
    base = wr_seen;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (wr_seen >= base + 1) break;
    end
    check("drop_first_write_seen", 32'(wr_seen >= base + 1), 32'd1);
    drop_at = cyc + 1;
  endtask

  initial begin
    int          bc;
    int          words;
    int          base;
    logic [31:0] last;
    logic [31:0] v;
    logic [31:0] s;
    logic [15:0] n;

    reset = 1'b0;
    data_bus_select = 1'b0;
    data_bus_mode   = 2'b00;
    data_bus_addr   = 32'd0;
    data_bus_write  = 32'd0;
    src_m = 0; dst_m = 0; cnt_m = 0; done_m = 0; irqen_m = 0; ie_w = 0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    verify_regs("reset");

    // Four-word copy with grant held.
    program_xfer(32'h1000, 32'h2000, 16'd4, 1'b0);
    start_and_wait(bc, last);
    check("copy4_busy_cycles", 32'(bc), 32'd14);
    check("copy4_ctrl_after", last, 32'h4);
    finish_model("copy4");
    cpu_read(4'h0, v); check("copy4_src_literal", v, 32'h1010);
    cpu_read(4'h4, v); check("copy4_dst_literal", v, 32'h2010);
    verify_regs("copy4");

    // Zero count: straight to done, no bus cycles.
    program_xfer(32'h3000, 32'h4000, 16'd0, 1'b0);
    start_and_wait(bc, last);
    check("zero_busy_cycles", 32'(bc), 32'd1);
    check("zero_ctrl_after", last, 32'h4);
    finish_model("zero");
    verify_regs("zero");

    // Grant dropped for two cycles during the second read.
    program_xfer(32'h5000, 32'h6000, 16'd3, 1'b0);
    fork
      start_and_wait(bc, last);
      drop_grant_second_rd();
    join
    check("stall_busy_cycles", 32'(bc), 32'd13);
    finish_model("stall");
    verify_regs("stall");

    // Source address wrap.
    program_xfer(32'hFFFF_FFFC, 32'h7000, 16'd2, 1'b0);
    start_and_wait(bc, last);
    finish_model("wrap");
    cpu_read(4'h0, v); check("wrap_src_literal", v, 32'h0000_0004);
    verify_regs("wrap");

    // Interrupt: level while DONE, cleared by write-1 to DONE.
    program_xfer(32'h7100, 32'h7200, 16'd1, 1'b1);
    start_and_wait(bc, last);
    finish_model("irq");
    verify_regs("irq");
`ifdef FEATURE_DMA_IRQ_EN
    check("irq_high_literal", 32'(dma_irq), 32'd1);
`endif
    cpu_write(4'hC, 32'({ie_w, 1'b1, 2'b00}));
    done_m = 1'b0;
    check("irq_cleared", 32'(dma_irq), 32'd0);
    verify_regs("irq_clr");

    // Abort after the second word; SRC write while busy must be ignored.
    program_xfer(32'h8000, 32'h9000, 16'd8, 1'b0);
    cpu_write(4'hC, 32'h1);
    base = wr_seen;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (wr_seen >= base + 2) break;
    end
    tick();
    cpu_write(4'hC, 32'h10);
    cpu_write(4'h0, 32'hDEAD_0000);
    poll_idle(bc, last);
    words = wr_seen - base;
    check("abort_words_2_or_3", 32'(words == 2 || words == 3), 32'd1);
    check("abort_leftover", 32'(expq.size()), 32'(2 * (8 - words)));
    expq.delete();
    src_m = 32'h8000 + 32'(4 * words);
    dst_m = 32'h9000 + 32'(4 * words);
    cnt_m = 16'(8 - words);
    verify_regs("abort");

    // Reset mid-transfer abandons it with no further bus cycles.
    program_xfer(32'hA000, 32'hB000, 16'd5, 1'b1);
    cpu_write(4'hC, 32'({ie_w, 3'b001}));
    repeat (4) tick();
    reset = 1'b0;
    expq.delete();
    repeat (3) tick();
    reset = 1'b1;
    src_m = 0; dst_m = 0; cnt_m = 0; done_m = 0; irqen_m = 0;
    repeat (5) tick();
    verify_regs("midreset");

    // Randomized transfers, half with random grant.
    for (int it = 0; it < 30; it++) begin
      s = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)) : $urandom;
      n = 16'($urandom_range(0, 6));
      grant_rand = bit'($urandom_range(0, 1));
      program_xfer(s, $urandom, n, 1'($urandom_range(0, 1)));
      verify_regs("rnd_prog");
      start_and_wait(bc, last);
      if (!grant_rand)
        check("rnd_busy_cycles", 32'(bc), (n == 16'd0) ? 32'd1 : 32'(3 * int'(n) + 2));
      finish_model("rnd");
      check("rnd_ctrl_after", last, ctrl_exp());
      verify_regs("rnd_done");
    end
    grant_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
